// File: rtl/ball_control_arbiter_if.sv
// Control bus between the input front-ends, the arbiter and the ball position block.
// master drives the two direction sources; slave is the arbiter producing tick/grant/ctrl.
interface ball_control_arbiter_if;
   logic [3:0] ctrl_a;
   logic [3:0] ctrl_b;
   logic       tick;
   logic [3:0] ctrl_out;
   logic [1:0] grant;
   logic       demo_active;

   modport master (
      output ctrl_a, ctrl_b,
      input  tick, ctrl_out, grant, demo_active
   );

   modport slave (
      input  ctrl_a, ctrl_b,
      output tick, ctrl_out, grant, demo_active
   );
endinterface

// File: rtl/ball_control_arbiter.sv
// Move-tick generator and round-robin/hold-limit arbiter between two direction sources.
// Optional idle demo mode is built when the macro AUTO_DEMO_EN is defined.
module ball_control_arbiter #(
   parameter int unsigned TICK_DIV   = 524289,
   parameter int unsigned HOLD_TICKS = 8,
   parameter int unsigned IDLE_TICKS = 64,
   parameter int unsigned DEMO_STEP  = 32
) (
   input logic                   clock,
   input logic                   reset,
   ball_control_arbiter_if.slave bus
);
   localparam int unsigned CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned HOLD_W = $clog2(HOLD_TICKS) + 1;
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TICK_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS - 1);

   if (TICK_DIV < 2 || HOLD_TICKS < 1 || IDLE_TICKS < 1 || DEMO_STEP < 1) begin : g_param_check
      $error("ball_control_arbiter: illegal parameter value");
   end

`ifdef AUTO_DEMO_EN
   localparam int unsigned IDLE_W = $clog2(IDLE_TICKS + 1);
   localparam int unsigned STEP_W = $clog2(DEMO_STEP + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TICKS - 1);
   localparam logic [IDLE_W-1:0] IDLE_FULL = IDLE_W'(IDLE_TICKS);
   localparam logic [STEP_W-1:0] STEP_FULL = STEP_W'(DEMO_STEP);

   typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, DEMO} state_t;
`else
   typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
`endif

   // Clear both bits of any opposing pair (up/down, left/right).
   function automatic logic [3:0] sanitise(input logic [3:0] c);
      logic [3:0] s;
      s = c;
      if (c[0] && c[2]) begin
         s[0] = 1'b0;
         s[2] = 1'b0;
      end
      if (c[1] && c[3]) begin
         s[1] = 1'b0;
         s[3] = 1'b0;
      end
      return s;
   endfunction

   state_t              state;
   logic [CNT_W-1:0]    tick_cnt;
   logic [HOLD_W-1:0]   hold_cnt;
   logic                prio_b;
   logic                tick;
   logic [3:0]          ctrl_out;
   logic [1:0]          grant;
   logic [3:0]          san_a;
   logic [3:0]          san_b;
   logic                req_a;
   logic                req_b;
   logic                wrap;
   logic                sel_a;
   logic                sel_b;
   logic                keep;

   assign san_a = sanitise(bus.ctrl_a);
   assign san_b = sanitise(bus.ctrl_b);
   assign req_a = |san_a;
   assign req_b = |san_b;
   assign wrap  = (tick_cnt == CNT_MAX);

   assign bus.tick     = tick;
   assign bus.ctrl_out = ctrl_out;
   assign bus.grant    = grant;

   // Owner choice for the coming decision edge; keep means the current owner stays.
   always_comb begin
      sel_a = 1'b0;
      sel_b = 1'b0;
      keep  = 1'b0;
      case (state)
         OWN_A: begin
            if (req_a && (!req_b || hold_cnt < HOLD_MAX)) begin
               sel_a = 1'b1;
               keep  = 1'b1;
            end else if (req_b) begin
               sel_b = 1'b1;
            end
         end
         OWN_B: begin
            if (req_b && (!req_a || hold_cnt < HOLD_MAX)) begin
               sel_b = 1'b1;
               keep  = 1'b1;
            end else if (req_a) begin
               sel_a = 1'b1;
            end
         end
         default: begin
            if (req_a && req_b) begin
               sel_a = !prio_b;
               sel_b = prio_b;
            end else begin
               sel_a = req_a;
               sel_b = req_b;
            end
         end
      endcase
   end

`ifdef AUTO_DEMO_EN
   logic [IDLE_W-1:0] idle_cnt;
   logic [STEP_W-1:0] demo_step;
   logic [1:0]        demo_idx;
   logic              demo_active;

   assign bus.demo_active = demo_active;

   function automatic logic [3:0] demo_pat(input logic [1:0] idx);
      case (idx)
         2'd0:    return 4'b1001;
         2'd1:    return 4'b1100;
         2'd2:    return 4'b0110;
         default: return 4'b0011;
      endcase
   endfunction
`else
   assign bus.demo_active = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         tick_cnt <= '0;
         hold_cnt <= '0;
         prio_b   <= 1'b0;
         tick     <= 1'b0;
         ctrl_out <= 4'b0000;
         grant    <= 2'b00;
`ifdef AUTO_DEMO_EN
         idle_cnt    <= '0;
         demo_step   <= '0;
         demo_idx    <= 2'd0;
         demo_active <= 1'b0;
`endif
      end else begin
         tick     <= wrap;
         tick_cnt <= wrap ? '0 : CNT_W'(tick_cnt + 1'b1);
         if (!wrap) begin
            ctrl_out <= 4'b0000;
         end else if (sel_a || sel_b) begin
            state    <= sel_a ? OWN_A : OWN_B;
            grant    <= sel_a ? 2'b01 : 2'b10;
            ctrl_out <= sel_a ? san_a : san_b;
            if (keep) begin
               hold_cnt <= (hold_cnt == HOLD_MAX) ? hold_cnt : HOLD_W'(hold_cnt + 1'b1);
            end else begin
               hold_cnt <= '0;
               prio_b   <= sel_a;
            end
`ifdef AUTO_DEMO_EN
            idle_cnt    <= '0;
            demo_active <= 1'b0;
`endif
         end else begin
            grant <= 2'b00;
`ifdef AUTO_DEMO_EN
            if (state == DEMO) begin
               if (demo_step == STEP_FULL) begin
                  demo_idx  <= 2'(demo_idx + 2'd1);
                  demo_step <= STEP_W'(1);
                  ctrl_out  <= demo_pat(2'(demo_idx + 2'd1));
               end else begin
                  demo_step <= STEP_W'(demo_step + 1'b1);
                  ctrl_out  <= demo_pat(demo_idx);
               end
            end else if (state == IDLE && idle_cnt >= IDLE_LAST) begin
               state       <= DEMO;
               demo_active <= 1'b1;
               idle_cnt    <= IDLE_FULL;
               demo_idx    <= 2'd0;
               demo_step   <= STEP_W'(1);
               ctrl_out    <= demo_pat(2'd0);
            end else begin
               if (state == IDLE) begin
                  idle_cnt <= IDLE_W'(idle_cnt + 1'b1);
               end
               state    <= IDLE;
               ctrl_out <= 4'b0000;
            end
`else
            state    <= IDLE;
            ctrl_out <= 4'b0000;
`endif
         end
      end
   end
endmodule

// File: tb/tb_ball_control_arbiter.sv
// Directed bench for ball_control_arbiter with TICK_DIV=4, HOLD_TICKS=3, IDLE_TICKS=4, DEMO_STEP=2.
// Demo-mode expectations are compiled in when AUTO_DEMO_EN is defined.
module tb_ball_control_arbiter;
   logic clock;
   logic reset;
   int   total;
   int   npass;
   int   nfail;

   ball_control_arbiter_if bus();

   ball_control_arbiter #(
      .TICK_DIV(4), .HOLD_TICKS(3), .IDLE_TICKS(4), .DEMO_STEP(2)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Advance one full tick period and check the tick cycle outputs.
   task automatic tick_chk(input string tag, input logic [3:0] ctrl, input logic [1:0] gnt,
                           input logic demo);
      cyc(4);
      chk({tag, ".tick"}, {3'b000, bus.tick}, 4'b0001);
      chk({tag, ".ctrl"}, bus.ctrl_out, ctrl);
      chk({tag, ".grant"}, {2'b00, bus.grant}, {2'b00, gnt});
      chk({tag, ".demo"}, {3'b000, bus.demo_active}, {3'b000, demo});
   endtask

   initial begin
      total = 0; npass = 0; nfail = 0;
      reset = 1'b1;
      bus.ctrl_a = 4'b0000;
      bus.ctrl_b = 4'b0000;

      // Reset and first tick
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      chk("rst.tick", {3'b000, bus.tick}, 4'b0000);
      chk("rst.ctrl", bus.ctrl_out, 4'b0000);
      chk("rst.grant", {2'b00, bus.grant}, 4'b0000);
      chk("rst.demo", {3'b000, bus.demo_active}, 4'b0000);
      cyc(3);
      chk("first.pre_tick", {3'b000, bus.tick}, 4'b0000);
      cyc(1);
      chk("first.tick", {3'b000, bus.tick}, 4'b0001);
      chk("first.ctrl", bus.ctrl_out, 4'b0000);
      chk("first.grant", {2'b00, bus.grant}, 4'b0000);

      // Single source A
      bus.ctrl_a = 4'b0001;
      cyc(1);
      chk("a.off_tick", {3'b000, bus.tick}, 4'b0000);
      chk("a.off_ctrl", bus.ctrl_out, 4'b0000);
      cyc(3);
      chk("a.t1.ctrl", bus.ctrl_out, 4'b0001);
      chk("a.t1.grant", {2'b00, bus.grant}, 4'b0001);
      tick_chk("a.t2", 4'b0001, 2'b01, 1'b0);

      // Opposing-direction sanitising
      bus.ctrl_a = 4'b0101;
      tick_chk("san.0101", 4'b0000, 2'b00, 1'b0);
      bus.ctrl_a = 4'b1111;
      tick_chk("san.1111", 4'b0000, 2'b00, 1'b0);
      bus.ctrl_a = 4'b0111;
      tick_chk("san.0111", 4'b0010, 2'b01, 1'b0);
      cyc(1);
      chk("san.off_ctrl", bus.ctrl_out, 4'b0000);
      chk("san.off_grant", {2'b00, bus.grant}, 4'b0001);

      // Both requesting from reset: round robin with hold limit 3
      reset = 1'b1;
      bus.ctrl_a = 4'b0001;
      bus.ctrl_b = 4'b1000;
      #1;
      chk("rr.async_grant", {2'b00, bus.grant}, 4'b0000);
      cyc(2);
      reset = 1'b0;
      tick_chk("rr.t1", 4'b0001, 2'b01, 1'b0);
      tick_chk("rr.t2", 4'b0001, 2'b01, 1'b0);
      tick_chk("rr.t3", 4'b0001, 2'b01, 1'b0);
      tick_chk("rr.t4", 4'b1000, 2'b10, 1'b0);
      tick_chk("rr.t5", 4'b1000, 2'b10, 1'b0);
      tick_chk("rr.t6", 4'b1000, 2'b10, 1'b0);
      tick_chk("rr.t7", 4'b0001, 2'b01, 1'b0);

      // Async reset mid-period while A owns; tick outputs clear without a clock edge
      bus.ctrl_a = 4'b0000;
      bus.ctrl_b = 4'b0000;
      cyc(2);
      chk("ar.held_grant", {2'b00, bus.grant}, 4'b0001);
      reset = 1'b1;
      #2;
      chk("ar.tick", {3'b000, bus.tick}, 4'b0000);
      chk("ar.ctrl", bus.ctrl_out, 4'b0000);
      chk("ar.grant", {2'b00, bus.grant}, 4'b0000);
      cyc(1);
      reset = 1'b0;
      tick_chk("ar.t1", 4'b0000, 2'b00, 1'b0);

      // Idle run: demo entry after the 4th idle decision, or stays idle without demo mode
      tick_chk("idle.t2", 4'b0000, 2'b00, 1'b0);
      tick_chk("idle.t3", 4'b0000, 2'b00, 1'b0);
`ifdef AUTO_DEMO_EN
      tick_chk("demo.t4", 4'b1001, 2'b00, 1'b1);
      cyc(1);
      chk("demo.off_ctrl", bus.ctrl_out, 4'b0000);
      chk("demo.off_active", {3'b000, bus.demo_active}, 4'b0001);
      cyc(3);
      chk("demo.t5.ctrl", bus.ctrl_out, 4'b1001);
      tick_chk("demo.t6", 4'b1100, 2'b00, 1'b1);
      tick_chk("demo.t7", 4'b1100, 2'b00, 1'b1);
      tick_chk("demo.t8", 4'b0110, 2'b00, 1'b1);
      bus.ctrl_b = 4'b0100;
      tick_chk("demo.exit", 4'b0100, 2'b10, 1'b0);
`else
      tick_chk("idle.t4", 4'b0000, 2'b00, 1'b0);
      tick_chk("idle.t5", 4'b0000, 2'b00, 1'b0);
      tick_chk("idle.t6", 4'b0000, 2'b00, 1'b0);
      bus.ctrl_b = 4'b0100;
      tick_chk("idle.exit", 4'b0100, 2'b10, 1'b0);
`endif

      // Lone requester keeps grant past the hold limit
      bus.ctrl_a = 4'b0001;
      bus.ctrl_b = 4'b0000;
      for (int i = 0; i < 5; i++) tick_chk("lone_a", 4'b0001, 2'b01, 1'b0);

      // Left/right pair cleared, up survives; then fully cancelled request
      bus.ctrl_a = 4'b0000;
      bus.ctrl_b = 4'b1011;
      tick_chk("sanb.1011", 4'b0001, 2'b10, 1'b0);
      bus.ctrl_b = 4'b1010;
      tick_chk("sanb.1010", 4'b0000, 2'b00, 1'b0);

      $display("%0d/%0d checks passed", npass, total);
      $finish;
   end
endmodule
